// File: rtl/hyper_block_mover_if.sv
// Command, status, DRAM-buffer and device-FIFO signals of the hyperfabric block mover.
// Pure wiring; no storage.
// slave is the mover's own view; master is the controller/memory/device side.
interface hyper_block_mover_if;
    logic [8:0]  blck_start;
    logic [5:0]  blck_count_req;
    logic        blck_issue;
    logic [1:0]  blck_section;
    logic [1:0]  rst_mvblck;
    logic [5:0]  blck_count_sent;
    logic        blck_working;
    logic        blck_irq;
    logic        blck_abrupt_stop;
    logic        blck_frdram_deverr;
    logic [8:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        dev_wr_en;
    logic [31:0] dev_wr_data;
    logic [3:0]  dev_full;
    logic        dev_rd_en;
    logic [31:0] dev_rd_data;
    logic [3:0]  dev_empty;
    logic [3:0]  dev_err;
    logic [3:0]  dev_irq;

    modport slave (
        input  blck_start, blck_count_req, blck_issue, blck_section, rst_mvblck,
        input  mem_rdata, dev_full, dev_rd_data, dev_empty, dev_err, dev_irq,
        output blck_count_sent, blck_working, blck_irq, blck_abrupt_stop, blck_frdram_deverr,
        output mem_addr, mem_re, mem_we, mem_wdata, dev_wr_en, dev_wr_data, dev_rd_en
    );

    modport master (
        output blck_start, blck_count_req, blck_issue, blck_section, rst_mvblck,
        output mem_rdata, dev_full, dev_rd_data, dev_empty, dev_err, dev_irq,
        input  blck_count_sent, blck_working, blck_irq, blck_abrupt_stop, blck_frdram_deverr,
        input  mem_addr, mem_re, mem_we, mem_wdata, dev_wr_en, dev_wr_data, dev_rd_en
    );
endinterface

// File: rtl/hyper_block_mover.sv
// Moves up to 63 words between the 512-word DRAM page buffer and one device FIFO section.
// DRAM reads are pushed MEM_LAT cycles after MEM_RE; device pops are written one cycle after DEV_RD_EN.
// Reads pause while the section is almost-full, pops while it is empty; a watchdog aborts stalls.
module hyper_block_mover #(
    parameter int MEM_LAT   = 2,
    parameter int STALL_MAX = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hyper_block_mover_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [8:0]         addr_q, addr_d;
    logic [5:0]         req_q, req_d;
    logic [5:0]         issued_q, issued_d;
    logic [5:0]         sent_q, sent_d;
    logic [1:0]         sec_q, sec_d;
    logic               dir_rd_q, dir_rd_d;
    logic               irq_q, irq_d;
    logic               stop_q, stop_d;
    logic               deverr_q, deverr_d;
    logic               abort_q, abort_d;
    logic [7:0]         wd_q, wd_d;
    logic [MEM_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic               pop_q, pop_d;

    logic active, dir_ok, err_now, drop_now, wd_hit, kill, aborting, more;
    logic mem_re, dev_rd_en, push, mem_we, moved;
    logic all_issued, inflight_d;

    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign dir_ok   = (bus.rst_mvblck == 2'b10) || (bus.rst_mvblck == 2'b01);
    assign err_now  = active && bus.dev_err[sec_q];
    assign drop_now = active && !dir_ok;
    // Fires so that WORKING falls exactly STALL_MAX cycles after the last clear.
    assign wd_hit   = active && (wd_q == 8'(STALL_MAX - 2));
    assign kill     = !abort_q && (err_now || drop_now || wd_hit);
    assign aborting = abort_q || kill;
    assign more     = (issued_q != req_q);

    // New requests stop in the very cycle an abort is seen; returns arriving then are dropped too.
    assign mem_re    = (state_q == S_RUN) && dir_rd_q && more && !bus.dev_full[sec_q] && !aborting;
    assign dev_rd_en = (state_q == S_RUN) && !dir_rd_q && more && !bus.dev_empty[sec_q] && !aborting;
    assign push      = rd_pipe_q[MEM_LAT-1] && !aborting;
    assign mem_we    = pop_q && !aborting;
    assign moved     = push || mem_we;

    // Next-state: handshakes, counters, sticky status and the transfer FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        req_d      = req_q;
        sec_d      = sec_q;
        dir_rd_d   = dir_rd_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        irq_d      = irq_q;
        stop_d     = stop_q;
        deverr_d   = deverr_q;
        abort_d    = abort_q;
        wd_d       = wd_q;
        pop_d      = dev_rd_en;
        rd_pipe_d  = '0;
        rd_pipe_d[0] = mem_re;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        if (mem_re || dev_rd_en) issued_d = issued_q + 6'd1;
        if (mem_re || mem_we)    addr_d   = addr_q + 9'd1;
        if (moved)               sent_d   = sent_q + 6'd1;
        if (active) begin
            wd_d  = moved ? 8'd0 : wd_q + 8'd1;
            irq_d = irq_q | bus.dev_irq[sec_q];
        end
        // Error outranks a direction drop, which outranks the watchdog; only the first abort counts.
        if (kill) begin
            abort_d  = 1'b1;
            deverr_d = err_now;
            stop_d   = !err_now;
        end

        all_issued = (issued_d == req_q);
        inflight_d = (|rd_pipe_d) | pop_d;

        case (state_q)
            S_IDLE: begin
                if (bus.blck_issue && dir_ok) begin
                    state_d  = S_RUN;
                    addr_d   = bus.blck_start;
                    req_d    = bus.blck_count_req;
                    sec_d    = bus.blck_section;
                    dir_rd_d = (bus.rst_mvblck == 2'b10);
                    issued_d = 6'd0;
                    sent_d   = 6'd0;
                    irq_d    = 1'b0;
                    stop_d   = 1'b0;
                    deverr_d = 1'b0;
                    abort_d  = 1'b0;
                    wd_d     = 8'd0;
                end
            end
            S_RUN: begin
                if (all_issued || aborting) state_d = inflight_d ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                if (!inflight_d) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset clearing every output-visible bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= 9'd0;
            req_q     <= 6'd0;
            sec_q     <= 2'd0;
            dir_rd_q  <= 1'b0;
            issued_q  <= 6'd0;
            sent_q    <= 6'd0;
            irq_q     <= 1'b0;
            stop_q    <= 1'b0;
            deverr_q  <= 1'b0;
            abort_q   <= 1'b0;
            wd_q      <= 8'd0;
            rd_pipe_q <= '0;
            pop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            sec_q     <= sec_d;
            dir_rd_q  <= dir_rd_d;
            issued_q  <= issued_d;
            sent_q    <= sent_d;
            irq_q     <= irq_d;
            stop_q    <= stop_d;
            deverr_q  <= deverr_d;
            abort_q   <= abort_d;
            wd_q      <= wd_d;
            rd_pipe_q <= rd_pipe_d;
            pop_q     <= pop_d;
        end
    end

    assign bus.blck_working       = active;
    assign bus.blck_count_sent    = sent_q;
    assign bus.blck_irq           = irq_q;
    assign bus.blck_abrupt_stop   = stop_q;
    assign bus.blck_frdram_deverr = deverr_q;
    assign bus.mem_addr           = addr_q;
    assign bus.mem_re             = mem_re;
    assign bus.mem_we             = mem_we;
    assign bus.mem_wdata          = mem_we ? bus.dev_rd_data : 32'd0;
    assign bus.dev_wr_en          = push;
    assign bus.dev_wr_data        = push ? bus.mem_rdata : 32'd0;
    assign bus.dev_rd_en          = dev_rd_en;

endmodule

// File: tb/tb_hyper_block_mover.sv
// Directed bench for hyper_block_mover: table of transfers plus reset sequences.
// DRAM model returns data MEM_LAT cycles after MEM_RE; FIFO model returns pop data next cycle.
// Cycle 0 of every transfer is the cycle carrying the ISSUE pulse.
module tb_hyper_block_mover;
    localparam int MEM_LAT   = 2;
    localparam int STALL_MAX = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hyper_block_mover_if bus();

    hyper_block_mover #(.MEM_LAT(MEM_LAT), .STALL_MAX(STALL_MAX)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] dir;
        logic [8:0] start;
        logic [5:0] cnt;
        logic [1:0] sec;
        int         fifo_n;
        int         full_lo;
        int         full_hi;
        int         err_at;
        int         drop_at;
        int         irq_at;
        int         reissue_at;
        bit         stuck_empty;
        int         exp_fall;
        int         exp_sent;
        int         exp_moves;
        bit         exp_irq;
        bit         exp_stop;
        bit         exp_deverr;
    } vec_t;

    vec_t tbl [10];
    int total = 0;
    int bad   = 0;

    logic [1:0]  cur_sec;
    bit          force_empty, full_on, err_on, irq_on;
    logic [31:0] fifo_mem [1024];
    int          pop_cnt  = 0;
    int          fifo_end = 0;
    logic [31:0] rdp [MEM_LAT];

    logic [8:0]  re_log[$];
    logic [31:0] push_log[$];
    logic [8:0]  we_addr[$];
    logic [31:0] we_dat[$];

    function automatic logic [31:0] dram_word(input logic [8:0] a);
        return 32'hA500_0000 | {23'd0, a};
    endfunction

    function automatic logic [31:0] fifo_word(input int idx, input int j);
        return 32'hC0DE_0000 + 32'(idx * 256 + j);
    endfunction

    // DRAM buffer read pipeline and device FIFO pop model.
    always @(posedge clk) begin
        rdp[0] <= bus.mem_re ? dram_word(bus.mem_addr) : 32'h0;
        for (int i = 1; i < MEM_LAT; i++) rdp[i] <= rdp[i-1];
        if (bus.dev_rd_en) begin
            bus.dev_rd_data <= fifo_mem[pop_cnt];
            pop_cnt <= pop_cnt + 1;
        end
    end
    assign bus.mem_rdata = rdp[MEM_LAT-1];

    // Only the selected section is live; the others look full/empty and quiet.
    always_comb begin
        bus.dev_empty = 4'hF;
        if (!force_empty && pop_cnt < fifo_end) bus.dev_empty[cur_sec] = 1'b0;
        bus.dev_full = 4'hF;
        bus.dev_full[cur_sec] = full_on;
        bus.dev_err = 4'h0;
        bus.dev_err[cur_sec] = err_on;
        bus.dev_irq = 4'h0;
        bus.dev_irq[cur_sec] = irq_on;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] dir, input logic [8:0] start,
                                input logic [5:0] cnt, input logic [1:0] sec, input int fifo_n,
                                input int full_lo, input int full_hi, input int err_at, input int drop_at,
                                input int irq_at, input int reissue_at, input bit stuck,
                                input int fall, input int sent, input int moves,
                                input bit irq, input bit stop, input bit deverr);
        vec_t v;
        v.name = n; v.dir = dir; v.start = start; v.cnt = cnt; v.sec = sec; v.fifo_n = fifo_n;
        v.full_lo = full_lo; v.full_hi = full_hi; v.err_at = err_at; v.drop_at = drop_at;
        v.irq_at = irq_at; v.reissue_at = reissue_at; v.stuck_empty = stuck;
        v.exp_fall = fall; v.exp_sent = sent; v.exp_moves = moves;
        v.exp_irq = irq; v.exp_stop = stop; v.exp_deverr = deverr;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.blck_issue = 1'b0;
        bus.rst_mvblck = 2'b00;
        full_on = 1'b0; err_on = 1'b0; irq_on = 1'b0; force_empty = 1'b0;
    endtask

    // Entered just after a rising edge; returns just after a rising edge with the DUT idle.
    task automatic run_case(input vec_t v, input int idx);
        int fall = -1;
        bit seen = 1'b0;
        int pop0 = pop_cnt;
        int moves;
        bit ok = 1'b1;
        logic [8:0] a;
        re_log.delete(); push_log.delete(); we_addr.delete(); we_dat.delete();
        cur_sec = v.sec;
        force_empty = v.stuck_empty;
        for (int j = 0; j < v.fifo_n; j++) fifo_mem[pop0 + j] = fifo_word(idx, j);
        fifo_end = pop0 + v.fifo_n;
        bus.blck_start = v.start;
        bus.blck_count_req = v.cnt;
        bus.blck_section = v.sec;
        bus.rst_mvblck = v.dir;
        bus.blck_issue = 1'b1;
        for (int c = 0; c < 400; c++) begin
            full_on = (v.full_lo > 0) && (c >= v.full_lo) && (c <= v.full_hi);
            err_on  = (v.err_at > 0) && (c == v.err_at);
            irq_on  = (v.irq_at > 0) && (c == v.irq_at);
            if (v.drop_at > 0 && c >= v.drop_at) bus.rst_mvblck = 2'b00;
            if (c > 0) bus.blck_issue = (v.reissue_at > 0) && (c == v.reissue_at);
            if (v.reissue_at > 0 && c == v.reissue_at) begin
                bus.blck_start = 9'h000;
                bus.blck_count_req = 6'd8;
            end
            @(negedge clk);
            if (bus.mem_re) re_log.push_back(bus.mem_addr);
            if (bus.dev_wr_en) push_log.push_back(bus.dev_wr_data);
            if (bus.mem_we) begin
                we_addr.push_back(bus.mem_addr);
                we_dat.push_back(bus.mem_wdata);
            end
            if (bus.blck_working) seen = 1'b1;
            else if (seen) begin
                fall = c;
                break;
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s.fall", v.name), 64'(fall), 64'(v.exp_fall));
        check($sformatf("%s.sent", v.name), 64'(bus.blck_count_sent), 64'(v.exp_sent));
        check($sformatf("%s.irq", v.name), 64'(bus.blck_irq), 64'(v.exp_irq));
        check($sformatf("%s.stop", v.name), 64'(bus.blck_abrupt_stop), 64'(v.exp_stop));
        check($sformatf("%s.deverr", v.name), 64'(bus.blck_frdram_deverr), 64'(v.exp_deverr));
        if (v.dir == 2'b10) begin
            moves = re_log.size();
            foreach (re_log[i]) begin
                a = v.start + 9'(i);
                if (re_log[i] !== a) ok = 1'b0;
            end
            if (push_log.size() != v.exp_sent) ok = 1'b0;
            foreach (push_log[i]) begin
                a = v.start + 9'(i);
                if (push_log[i] !== dram_word(a)) ok = 1'b0;
            end
            if (we_addr.size() != 0) ok = 1'b0;
        end else begin
            moves = pop_cnt - pop0;
            if (we_addr.size() != v.exp_sent) ok = 1'b0;
            foreach (we_addr[i]) begin
                a = v.start + 9'(i);
                if (we_addr[i] !== a || we_dat[i] !== fifo_word(idx, i)) ok = 1'b0;
            end
            if (re_log.size() != 0 || push_log.size() != 0) ok = 1'b0;
        end
        check($sformatf("%s.moves", v.name), 64'(moves), 64'(v.exp_moves));
        check($sformatf("%s.data", v.name), 64'(ok), 64'd1);
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.blck_start = 9'd0;
        bus.blck_count_req = 6'd0;
        bus.blck_section = 2'd0;
        cur_sec = 2'd0;
        idle_inputs();

        //            name       dir    start   cnt  sec fifo flo fhi err drop irq reiss stuck fall sent mv irq stop derr
        tbl[0] = mk("rdmem",   2'b10, 9'h010, 6'd8, 2'd0, 0,  0,  0,  0,  0,  0,  0,   0,   11,  8,  8, 0, 0, 0);
        tbl[1] = mk("wrwrap",  2'b01, 9'h1fe, 6'd4, 2'd1, 4,  0,  0,  0,  0,  0,  0,   0,    6,  4,  4, 0, 0, 0);
        tbl[2] = mk("backpr",  2'b10, 9'h040, 6'd6, 2'd2, 0,  3, 10,  0,  0,  0,  0,   0,   17,  6,  6, 0, 0, 0);
        tbl[3] = mk("deverr",  2'b10, 9'h080, 6'd8, 2'd3, 0,  0,  0,  6,  0,  0,  0,   0,    8,  3,  5, 0, 0, 1);
        tbl[4] = mk("stall",   2'b01, 9'h020, 6'd5, 2'd0, 0,  0,  0,  0,  0,  0,  0,   1,  255,  0,  0, 0, 1, 0);
        tbl[5] = mk("zero",    2'b10, 9'h000, 6'd0, 2'd1, 0,  0,  0,  0,  0,  0,  0,   0,    2,  0,  0, 0, 0, 0);
        tbl[6] = mk("drop",    2'b10, 9'h1f0, 6'd8, 2'd2, 0,  0,  0,  0,  4,  0,  0,   0,    6,  1,  3, 0, 1, 0);
        tbl[7] = mk("errdrop", 2'b10, 9'h100, 6'd8, 2'd0, 0,  0,  0,  4,  4,  0,  0,   0,    6,  1,  3, 0, 0, 1);
        tbl[8] = mk("reissue", 2'b10, 9'h100, 6'd4, 2'd3, 0,  0,  0,  0,  0,  2,  2,   0,    7,  4,  4, 1, 0, 0);
        tbl[9] = mk("wrmem3",  2'b01, 9'h005, 6'd3, 2'd2, 3,  0,  0,  0,  0,  0,  0,   0,    5,  3,  3, 0, 0, 0);

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.status", 64'({bus.blck_working, bus.blck_irq, bus.blck_abrupt_stop,
                                 bus.blck_frdram_deverr, bus.blck_count_sent}), 64'd0);
        check("rst.mem", 64'({bus.mem_addr, bus.mem_re, bus.mem_we}), 64'd0);
        check("rst.wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst.dev", 64'({bus.dev_wr_en, bus.dev_rd_en, bus.dev_wr_data}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 10; k++) run_case(tbl[k], k);

        // Reset in the middle of a DRAM->device transfer.
        cur_sec = 2'd0;
        bus.blck_start = 9'h030;
        bus.blck_count_req = 6'd8;
        bus.blck_section = 2'd0;
        bus.rst_mvblck = 2'b10;
        bus.blck_issue = 1'b1;
        @(posedge clk); #1;
        bus.blck_issue = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst.busy", 64'({bus.blck_working, bus.mem_re, bus.blck_count_sent}), 64'({1'b1, 1'b1, 6'd1}));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst.status", 64'({bus.blck_working, bus.blck_irq, bus.blck_abrupt_stop,
                                    bus.blck_frdram_deverr, bus.blck_count_sent}), 64'd0);
        check("midrst.mem", 64'({bus.mem_addr, bus.mem_re, bus.mem_we}), 64'd0);
        check("midrst.dev", 64'({bus.dev_wr_en, bus.dev_rd_en, bus.dev_wr_data}), 64'd0);
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        run_case(tbl[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
